// File: rtl/mod_add.sv
// Modular adder/subtractor over Z_q with a combinational result, a registered
// copy qualified by valid, and an operand range-check flag.
module mod_add #(
    parameter int unsigned Q     = 3329,
    parameter int unsigned WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] op1_i,
    input  logic [WIDTH-1:0] op2_i,
    input  logic             sub_i,
    input  logic             valid_i,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] result_q_o,
    output logic             valid_o,
    output logic             range_err_o
);

    // One guard bit keeps the raw sum/difference exact before correction.
    localparam int unsigned SW = WIDTH + 1;

    logic [SW-1:0]    q_ext;
    logic [SW-1:0]    sum_c;
    logic [SW-1:0]    diff_c;
    logic [WIDTH-1:0] result_c;

    logic [WIDTH-1:0] result_reg_d, result_reg_q;
    logic             valid_d, valid_q;

    assign q_ext  = SW'(Q);
    assign sum_c  = SW'(op1_i) + SW'(op2_i);
    assign diff_c = SW'(op1_i) - SW'(op2_i);

    // Single conditional correction; the top bit of diff_c is its sign.
    always_comb begin
        result_c = '0;
        if (sub_i) begin
            if (diff_c[SW-1]) begin
                result_c = WIDTH'(diff_c + q_ext);
            end else begin
                result_c = WIDTH'(diff_c);
            end
        end else begin
            if (sum_c >= q_ext) begin
                result_c = WIDTH'(sum_c - q_ext);
            end else begin
                result_c = WIDTH'(sum_c);
            end
        end
    end

    assign result_o    = result_c;
    assign range_err_o = (op1_i >= WIDTH'(Q)) || (op2_i >= WIDTH'(Q));

    always_comb begin
        valid_d      = valid_i;
        result_reg_d = result_reg_q;
        if (valid_i) begin
            result_reg_d = result_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_reg_q <= '0;
            valid_q      <= 1'b0;
        end else begin
            result_reg_q <= result_reg_d;
            valid_q      <= valid_d;
        end
    end

    assign result_q_o = result_reg_q;
    assign valid_o    = valid_q;

endmodule

// File: tb/tb_mod_add.sv
// Self-checking bench for mod_add: directed vector table, randomized stress
// against an arithmetic reference, and registered-path/reset sequences.
module tb_mod_add;

    localparam int unsigned Q     = 3329;
    localparam int unsigned WIDTH = 12;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] op1_i;
    logic [WIDTH-1:0] op2_i;
    logic             sub_i;
    logic             valid_i;
    logic [WIDTH-1:0] result_o;
    logic [WIDTH-1:0] result_q_o;
    logic             valid_o;
    logic             range_err_o;

    int n_cmp = 0;
    int n_bad = 0;

    mod_add #(.Q(Q), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op1_i      (op1_i),
        .op2_i      (op2_i),
        .sub_i      (sub_i),
        .valid_i    (valid_i),
        .result_o   (result_o),
        .result_q_o (result_q_o),
        .valid_o    (valid_o),
        .range_err_o(range_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    a;
        int    b;
        bit    sub;
        int    exp_res;
        bit    exp_err;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int ref_mod(input int a, input int b, input bit sub);
        int r;
        if (sub) r = ((a - b) % int'(Q) + int'(Q)) % int'(Q);
        else     r = (a + b) % int'(Q);
        return r;
    endfunction

    task automatic drive(input int a, input int b, input bit sub, input bit v);
        op1_i   = WIDTH'(a);
        op2_i   = WIDTH'(b);
        sub_i   = sub;
        valid_i = v;
    endtask

    vec_t vecs[$];

    initial begin
        int a;
        int b;
        vecs.push_back('{"add_small",   10,   20,   1'b0, 30,   1'b0});
        vecs.push_back('{"add_zero",    0,    0,    1'b0, 0,    1'b0});
        vecs.push_back('{"add_wrap",    3328, 1,    1'b0, 0,    1'b0});
        vecs.push_back('{"add_large",   3000, 3000, 1'b0, 2671, 1'b0});
        vecs.push_back('{"add_max",     3328, 3328, 1'b0, 3327, 1'b0});
        vecs.push_back('{"sub_pos",     20,   10,   1'b1, 10,   1'b0});
        vecs.push_back('{"sub_neg",     10,   20,   1'b1, 3319, 1'b0});
        vecs.push_back('{"sub_min",     0,    3328, 1'b1, 1,    1'b0});
        vecs.push_back('{"sub_same",    1234, 1234, 1'b1, 0,    1'b0});
        vecs.push_back('{"range_op1",   3329, 0,    1'b0, 0,    1'b1});
        vecs.push_back('{"range_op2",   5,    4095, 1'b0, 771,  1'b1});

        rst_n = 1'b0;
        drive(0, 0, 1'b0, 1'b0);
        #2;
        check("reset_valid_o", int'(valid_o), 0);
        check("reset_result_q_o", int'(result_q_o), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(posedge clk);
            #1 drive(vecs[i].a, vecs[i].b, vecs[i].sub, 1'b0);
            @(negedge clk);
            check({vecs[i].name, "_res"}, int'(result_o), vecs[i].exp_res);
            check({vecs[i].name, "_err"}, int'(range_err_o), int'(vecs[i].exp_err));
        end

        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < 60; k++) begin
                a = int'($urandom_range(Q - 1, 0));
                b = int'($urandom_range(Q - 1, 0));
                @(posedge clk);
                #1 drive(a, b, s[0], 1'b0);
                @(negedge clk);
                check(s == 0 ? "rand_add" : "rand_sub", int'(result_o), ref_mod(a, b, s[0]));
                check("rand_range_err", int'(range_err_o), 0);
            end
        end

        // Registered path: capture, hold, then asynchronous reset mid-stream.
        @(posedge clk);
        #1 drive(3000, 3000, 1'b0, 1'b1);
        @(posedge clk);
        #1 drive(5, 5, 1'b0, 1'b0);
        @(negedge clk);
        check("reg_capture_valid", int'(valid_o), 1);
        check("reg_capture_result", int'(result_q_o), 2671);
        check("reg_comb_follow", int'(result_o), 10);
        @(posedge clk);
        #1 drive(10, 20, 1'b0, 1'b1);
        @(negedge clk);
        check("reg_hold_valid", int'(valid_o), 0);
        check("reg_hold_result", int'(result_q_o), 2671);
        @(posedge clk);
        #1 drive(10, 20, 1'b0, 1'b1);
        @(negedge clk);
        check("reg_second_valid", int'(valid_o), 1);
        check("reg_second_result", int'(result_q_o), 30);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_valid", int'(valid_o), 0);
        check("async_rst_result", int'(result_q_o), 0);
        check("async_rst_comb", int'(result_o), 30);
        @(posedge clk);
        #1 drive(3329, 0, 1'b0, 1'b1);
        @(negedge clk);
        check("in_rst_valid", int'(valid_o), 0);
        check("in_rst_result", int'(result_q_o), 0);
        check("in_rst_range_err", int'(range_err_o), 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1 drive(7, 9, 1'b1, 1'b0);
        @(negedge clk);
        check("post_rst_valid", int'(valid_o), 1);
        check("post_rst_result", int'(result_q_o), 0);
        check("post_rst_comb", int'(result_o), ref_mod(7, 9, 1'b1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mod_add.md
Name: mod_add

Overview:
- Modular adder/subtractor over Z_q for the polynomial-arithmetic datapath (ML-KEM, FIPS 203, q = 3329).
- Primary output result_o is purely combinational (0-cycle latency); the NTT/poly-add units consume it in the same cycle.
- A secondary registered copy with a valid flag is provided for pipelined consumers, plus an input range-check flag.

Parameters:
- Q, 3329, modulus; must satisfy Q < 2**WIDTH.
- WIDTH, 12, coefficient width in bits (coeff_t).

Ports:
- clk  in  1  rising-edge clock; used only by the registered path.
- rst_n  in  1  asynchronous active-low reset; clears the registered path only.
- op1_i  in  WIDTH  operand a, canonical range [0, Q-1].
- op2_i  in  WIDTH  operand b, canonical range [0, Q-1].
- sub_i  in  1  0 = a+b mod Q; 1 = a-b mod Q.
- valid_i  in  1  captures the current result into the registered path.
- result_o  out  WIDTH  combinational result, 0-cycle latency.
- result_q_o  out  WIDTH  registered result, 1-cycle latency.
- valid_o  out  1  result_q_o valid, 1-cycle delayed copy of valid_i.
- range_err_o  out  1  combinational flag: op1_i >= Q or op2_i >= Q.

Behaviour:
- Add (sub_i=0):
  - sum = op1_i + op2_i, computed at WIDTH+1 bits, no overflow.
  - result_o = (sum >= Q) ? sum - Q : sum[WIDTH-1:0].
  - Exactly one conditional subtraction.
- Subtract (sub_i=1):
  - diff = op1_i - op2_i, computed signed at WIDTH+1 bits.
  - result_o = (diff < 0) ? diff + Q : diff, truncated to WIDTH.
- result_o depends only on op1_i, op2_i and sub_i. It is independent of clk and rst_n, and is valid within the same cycle the inputs change.
- No latches; every combinational path must be fully assigned.
- Canonical inputs always give result_o in [0, Q-1].
  - Add boundaries: Q-1 + 1 -> 0; Q-1 + Q-1 -> Q-2; 0 + 0 -> 0.
  - Subtract boundaries: 0 - (Q-1) -> 1; x - x -> 0.
- Non-canonical inputs (>= Q) are not reduced further; the single-correction formula applies and the result is truncated to WIDTH bits. range_err_o is 1 whenever either operand is >= Q, else 0.
- Registered path:
  - On posedge clk: valid_o <= valid_i.
  - If valid_i=1: result_q_o <= result_o. If valid_i=0: result_q_o holds its value.
- Reset:
  - rst_n low asynchronously forces result_q_o = 0 and valid_o = 0.
  - Release is synchronous to the next clk edge.
  - Reset asserted mid-stream drops any pending registered result; result_o and range_err_o keep tracking the inputs.

Test Plan:
- Add, no reduction and zeros: 10+20 -> result_o 30; 0+0 -> 0. Check at the negedge of the cycle the inputs were driven.
- Add wrap and large values: 3328+1 -> 0; 3000+3000 -> 2671; 3328+3328 -> 3327.
- Subtract: 20-10 -> 10; 10-20 -> 3319; 0-3328 -> 1; 1234-1234 -> 0.
- Random stress:
  - 50+ pairs uniform in [0, 3328] for each sub_i value.
  - Compare result_o against a golden (a±b) mod 3329 in the same cycle.
  - Report pass/fail counts; zero failures required.
- Registered path:
  - valid_i pulse with 3000+3000 -> next cycle valid_o=1 and result_q_o=2671.
  - valid_i=0 -> valid_o=0 and result_q_o holds 2671.
  - Assert rst_n=0 mid-stream -> result_q_o=0 and valid_o=0 immediately, without waiting for a clock edge.
- Range flag: op1_i=3329, op2_i=0 -> range_err_o=1, result_o=0. Both operands canonical -> range_err_o=0.
